// File: rtl/shift141_ctl_pkg.sv
// rtl/shift141_ctl_pkg.sv - shared types for the mc10141 chain sequencer
// Purpose : mode, fill-policy and state enums used by shift141_ctl and shift141_fill.
// Ports   : none (package).
// Config  : SHIFT141_ROTATE_EN is consumed by shift141_fill, not here.
package shift141_ctl_pkg;

  // mc10141 select encoding (S1,S0): parallel entry, shift right, shift left, hold.
  typedef enum logic [1:0] {
    MODE_LOAD   = 2'b00,
    MODE_SHIFTR = 2'b01,
    MODE_SHIFTL = 2'b10,
    MODE_HOLD   = 2'b11
  } tMode141;

  typedef enum logic [1:0] {
    FILL_ZERO  = 2'd0,
    FILL_ONE   = 2'd1,
    FILL_ROT   = 2'd2,
    FILL_ARITH = 2'd3
  } tFill141;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } tShift141State;

endpackage

// File: rtl/shift141_fill.sv
// rtl/shift141_fill.sv - serial-in source mux for both ends of the chain
// Purpose : picks the bit fed into chain bit 0 (shift left) or the last bit (shift right).
// Ports   : dir (1=shift left), fill (tFill141), shifting (controller in SHIFT),
//           q0Out/qNOut (live chain ends) -> d0In, d3In.
// Config  : SHIFT141_ROTATE_EN enables ROT/ARITH; otherwise they fill 0 and the
//           chain-end inputs are unused.
module shift141_fill
  import shift141_ctl_pkg::*;
(
  input  logic    dir,
  input  tFill141 fill,
  input  logic    shifting,
  input  logic    q0Out,
  input  logic    qNOut,
  output logic    d0In,
  output logic    d3In
);

  logic w_fill_bit;

`ifndef SHIFT141_ROTATE_EN
  logic w_unused_ends;
  assign w_unused_ends = q0Out ^ qNOut;
`endif

  always_comb begin
    w_fill_bit = 1'b0;
    d0In       = 1'b0;
    d3In       = 1'b0;
    case (fill)
      FILL_ONE:   w_fill_bit = 1'b1;
`ifdef SHIFT141_ROTATE_EN
      // Rotate wraps the bit leaving the far end; arithmetic replicates the sign
      // on a left shift (bit 0 is the MSB) and zero-fills on a right shift.
      FILL_ROT:   w_fill_bit = dir ? qNOut : q0Out;
      FILL_ARITH: w_fill_bit = dir ? q0Out : 1'b0;
`endif
      default:    w_fill_bit = 1'b0;
    endcase
    if (shifting) begin
      if (dir) d0In = w_fill_bit;
      else     d3In = w_fill_bit;
    end
  end

endmodule

// File: rtl/shift141_ctl.sv
// rtl/shift141_ctl.sv - sequencer driving LOAD/SHIFT/HOLD on a cascaded mc10141 chain
// Purpose : on start, optionally loads the chain once, shifts it exactly count
//           times, returns it to HOLD and pulses done.
// Ports   : clk, resetN (async, active low); start, loadEn, dirL, count, fill
//           (request, sampled in IDLE); q0Out/qNOut (chain ends); s (chain mode),
//           d0In/d3In (serial-in), busy, done.
// Config  : SHIFT141_ROTATE_EN (see shift141_fill) enables ROT/ARITH fills.
module shift141_ctl
  import shift141_ctl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic             loadEn,
  input  logic             dirL,
  input  logic [CNT_W-1:0] count,
  input  logic [1:0]       fill,
  input  logic             q0Out,
  input  logic             qNOut,
  output logic [1:0]       s,
  output logic             d0In,
  output logic             d3In,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  tShift141State    r_state;
  logic             r_dir;
  tFill141          r_fill;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  tMode141          w_mode;
  logic             w_shifting;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
      r_fill  <= FILL_ZERO;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      // done trails the DONE state by one edge so the pulse lands 1+loadEn+count
      // edges after acceptance.
      r_done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_dir  <= dirL;
            r_fill <= tFill141'(fill);
            r_cnt  <= count;
            if (loadEn)              r_state <= ST_LOAD;
            else if (count != '0)    r_state <= ST_SHIFT;
            else                     r_state <= ST_DONE;
          end
        end
        ST_LOAD:  r_state <= (r_cnt != '0) ? ST_SHIFT : ST_DONE;
        ST_SHIFT: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= ST_DONE;
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_shifting = (r_state == ST_SHIFT);
    case (r_state)
      ST_LOAD:  w_mode = MODE_LOAD;
      ST_SHIFT: w_mode = r_dir ? MODE_SHIFTL : MODE_SHIFTR;
      default:  w_mode = MODE_HOLD;
    endcase
  end

  assign s    = w_mode;
  assign busy = (r_state != ST_IDLE);
  assign done = r_done;

  shift141_fill u_fill (
    .dir      (r_dir),
    .fill     (r_fill),
    .shifting (w_shifting),
    .q0Out    (q0Out),
    .qNOut    (qNOut),
    .d0In     (d0In),
    .d3In     (d3In)
  );

endmodule

// File: tb/tb_shift141_ctl.sv
// tb/tb_shift141_ctl.sv - directed scoreboard bench for shift141_ctl on one 4-bit mc10141
module tb_shift141_ctl;
  import shift141_ctl_pkg::*;

  localparam int CNT_W = 6;

  logic             clk    = 1'b0;
  logic             resetN = 1'b0;
  logic             start  = 1'b0;
  logic             loadEn = 1'b0;
  logic             dirL   = 1'b0;
  logic [CNT_W-1:0] count  = '0;
  logic [1:0]       fill   = 2'd0;
  logic [1:0]       s;
  logic             d0In, d3In, busy, done;

  // chain bit i is r_q[i]; bit 0 is the MSB, so %b prints q0..q3
  logic [0:3] r_q;
  logic [0:3] tb_d = 4'b0000;
  logic [0:3] exp_q;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    logic [0:3] q;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  shift141_ctl #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetN (resetN),
    .start  (start),
    .loadEn (loadEn),
    .dirL   (dirL),
    .count  (count),
    .fill   (fill),
    .q0Out  (r_q[0]),
    .qNOut  (r_q[3]),
    .s      (s),
    .d0In   (d0In),
    .d3In   (d3In),
    .busy   (busy),
    .done   (done)
  );

  // mc10141 stand-in: not reset, so it holds across a controller reset
  always_ff @(posedge clk) begin
    case (s)
      MODE_LOAD:   r_q <= tb_d;
      MODE_SHIFTL: r_q <= {d0In, r_q[0:2]};
      MODE_SHIFTR: r_q <= {r_q[1:3], d3In};
      default:     r_q <= r_q;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [0:3] model(input logic [0:3] qi, input logic dl,
                                       input logic [1:0] fl, input int cnt);
    logic [0:3] q;
    logic       b;
    q = qi;
    for (int i = 0; i < cnt; i++) begin
      case (fl)
        2'd1: b = 1'b1;
`ifdef SHIFT141_ROTATE_EN
        2'd2: b = dl ? q[3] : q[0];
        2'd3: b = dl ? q[0] : 1'b0;
`endif
        default: b = 1'b0;
      endcase
      q = dl ? {b, q[0:2]} : {q[1:3], b};
    end
    return q;
  endfunction

  // imm: start in the current (IDLE) cycle without waiting; post: check quiet idle after done
  task automatic do_op(input string tag, input logic le, input logic [0:3] dv,
                       input logic dl, input logic [1:0] fl, input int cnt,
                       input logic poke, input logic imm, input logic post);
    exp_t    e;
    exp_t    got;
    int      m;
    int      le_i;
    logic    seen;
    tMode141 exp_s;
    le_i  = le ? 1 : 0;
    e.tag = tag;
    e.q   = model(le ? dv : exp_q, dl, fl, cnt);
    e.lat = 1 + le_i + cnt;
    sb.push_back(e);
    exp_q = e.q;
    if (!imm) @(negedge clk);
    start  = 1'b1;
    loadEn = le;
    tb_d   = dv;
    dirL   = dl;
    fill   = fl;
    count  = cnt[CNT_W-1:0];
    @(posedge clk);
    @(negedge clk);
    // scramble request inputs: they must not matter after acceptance
    start  = 1'b0;
    loadEn = ~le;
    dirL   = ~dl;
    fill   = ~fl;
    count  = '1;
    m    = 0;
    seen = 1'b0;
    while (!seen && m <= e.lat + 4) begin
      if (m < le_i)             exp_s = MODE_LOAD;
      else if (m < le_i + cnt)  exp_s = dl ? MODE_SHIFTL : MODE_SHIFTR;
      else                      exp_s = MODE_HOLD;
      chk($sformatf("%s s@%0d", tag, m), s, exp_s);
      chk($sformatf("%s busy@%0d", tag, m), busy, (m < e.lat) ? 1 : 0);
      if (exp_s == MODE_SHIFTL)      chk($sformatf("%s d3In@%0d", tag, m), d3In, 0);
      else if (exp_s == MODE_SHIFTR) chk($sformatf("%s d0In@%0d", tag, m), d0In, 0);
      else                           chk($sformatf("%s serial@%0d", tag, m), {d0In, d3In}, 0);
      if (done) begin
        seen = 1'b1;
        got  = sb.pop_front();
        chk({got.tag, " q"}, r_q, got.q);
        chk({got.tag, " latency"}, m, got.lat);
      end else begin
        start = (poke && m == 1);
        @(posedge clk);
        @(negedge clk);
        m++;
      end
    end
    start = 1'b0;
    chk({tag, " done seen"}, seen, 1);
    if (post) begin
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        chk($sformatf("%s idle done+%0d", tag, i), {done, busy}, 0);
        chk($sformatf("%s idle s+%0d", tag, i), s, MODE_HOLD);
      end
    end
  endtask

  initial begin
    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst s", s, MODE_HOLD);
    chk("rst busy/done", {busy, done}, 0);
    chk("rst serial", {d0In, d3In}, 0);
    resetN = 1'b1;

    do_op("t1 shl zero", 1'b1, 4'b1010, 1'b1, 2'd0, 2, 1'b0, 1'b0, 1'b1);
    do_op("t2a shl rot1", 1'b1, 4'b0001, 1'b1, 2'd2, 1, 1'b0, 1'b0, 1'b0);
    do_op("t2b shl rot4", 1'b1, 4'b0001, 1'b1, 2'd2, 4, 1'b0, 1'b1, 1'b1);
    do_op("t3 shl arith", 1'b1, 4'b1000, 1'b1, 2'd3, 2, 1'b0, 1'b0, 1'b1);
    do_op("t4 shr one", 1'b1, 4'b0000, 1'b0, 2'd1, 3, 1'b1, 1'b0, 1'b1);
    do_op("t5 noload cnt0", 1'b0, 4'b1010, 1'b1, 2'd1, 0, 1'b0, 1'b0, 1'b1);
    do_op("t5b shr rot3", 1'b0, 4'b0000, 1'b0, 2'd2, 3, 1'b0, 1'b0, 1'b1);
    do_op("t6 preload", 1'b1, 4'b1000, 1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0);

    // reset mid-shift: SHIFTR ONE count=5, abort after two shifts
    start  = 1'b1;
    loadEn = 1'b0;
    dirL   = 1'b0;
    fill   = 2'd1;
    count  = 6'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t6 q after 2", r_q, 4'b0011);
    chk("t6 d3In shifting", d3In, 1);
    chk("t6 busy shifting", busy, 1);
    resetN = 1'b0;
    #1;
    chk("t6 rst s", s, MODE_HOLD);
    chk("t6 rst busy/done", {busy, done}, 0);
    chk("t6 rst serial", {d0In, d3In}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t6 hold q+%0d", i), r_q, 4'b0011);
      chk($sformatf("t6 no done+%0d", i), done, 0);
    end
    resetN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("t6 post s+%0d", i), s, MODE_HOLD);
      chk($sformatf("t6 post done+%0d", i), {busy, done}, 0);
    end
    chk("sb empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
